// File: rtl/msu_pkg.sv
// msu_pkg: shared sizing constants for the squarer output path.
//   SqSumBits - width of one squarer column sum
//   WordBits  - width of one canonical output limb
//   SqNumCols - column sums per squarer frame
package msu_pkg;
  localparam int SqSumBits = 28;
  localparam int WordBits  = 16;
  localparam int SqNumCols = 8;
endpackage

// File: rtl/sq_carry_split_if.sv
// sq_carry_split_if: column-sum input stream and limb output stream.
//   sum_i/sum_valid_i/sum_ready_o               - column sum handshake
//   word_o/word_valid_o/word_last_o/word_ready_i - limb handshake
//   busy_o                                      - frame in progress
// Port suffixes are from the splitter's point of view (slave modport).
interface sq_carry_split_if #(
  parameter int SumBits  = msu_pkg::SqSumBits,
  parameter int WordBits = msu_pkg::WordBits
);
  logic [SumBits-1:0]  sum_i;
  logic                sum_valid_i;
  logic                sum_ready_o;
  logic [WordBits-1:0] word_o;
  logic                word_valid_o;
  logic                word_last_o;
  logic                word_ready_i;
  logic                busy_o;

  modport slave (
    input  sum_i, sum_valid_i, word_ready_i,
    output sum_ready_o, word_o, word_valid_o, word_last_o, busy_o
  );

  modport master (
    output sum_i, sum_valid_i, word_ready_i,
    input  sum_ready_o, word_o, word_valid_o, word_last_o, busy_o
  );
endinterface

// File: rtl/sq_carry_split.sv
// sq_carry_split: sequential carry-propagating splitter.
// Accepts NumCols column sums per frame (LS column first), adds the running
// carry, emits WordBits-wide limbs, then flushes the residual carry as
// FlushWords extra limbs (the last one flagged word_last_o).
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - slave side of sq_carry_split_if (sum in, limb out, busy)
module sq_carry_split #(
  parameter int SumBits    = msu_pkg::SqSumBits,
  parameter int WordBits   = msu_pkg::WordBits,
  parameter int NumCols    = msu_pkg::SqNumCols,
  parameter int CarryBits  = SumBits - WordBits + 1,
  parameter int FlushWords = (CarryBits + WordBits - 1) / WordBits
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sq_carry_split_if.slave  bus
);
  localparam int CcW    = (NumCols > 1) ? $clog2(NumCols) : 1;
  localparam int FcW    = (FlushWords > 1) ? $clog2(FlushWords) : 1;
  localparam int FlushW = FlushWords * WordBits;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [CcW-1:0]       col_cnt_q, col_cnt_d;
  logic [FcW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [CarryBits-1:0] carry_q, carry_d;
  logic [WordBits-1:0]  word_q, word_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;

  logic                 slot_free;
  logic [SumBits:0]     t;
  // Carry zero-extended to a whole number of limbs so flushing is a plain slice.
  logic [FlushW-1:0]    carry_w;

  assign slot_free = !vld_q || bus.word_ready_i;
  assign carry_w   = FlushW'(carry_q);
  assign t         = {1'b0, bus.sum_i} + (SumBits+1)'(carry_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      col_cnt_q   <= '0;
      flush_cnt_q <= '0;
      carry_q     <= '0;
      word_q      <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      carry_q     <= carry_d;
      word_q      <= word_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    flush_cnt_d = flush_cnt_q;
    carry_d     = carry_q;
    word_d      = word_q;
    vld_d       = vld_q;
    last_d      = last_q;
    bus.sum_ready_o = 1'b0;

    unique case (state_q)
      RUN: begin
        bus.sum_ready_o = slot_free;
        if (slot_free) begin
          vld_d = 1'b0;  // slot drained with nothing new to load
          if (bus.sum_valid_i) begin
            word_d  = t[WordBits-1:0];
            last_d  = 1'b0;
            vld_d   = 1'b1;
            carry_d = CarryBits'(t >> WordBits);
            if (col_cnt_q == CcW'(NumCols - 1)) begin
              col_cnt_d = '0;
              state_d   = FLUSH;
            end else begin
              col_cnt_d = col_cnt_q + 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          word_d = carry_w[WordBits-1:0];
          vld_d  = 1'b1;
          if (flush_cnt_q == FcW'(FlushWords - 1)) begin
            // Final flush limb: frame closes, no carry leaks into the next one.
            last_d      = 1'b1;
            carry_d     = '0;
            flush_cnt_d = '0;
            state_d     = RUN;
          end else begin
            last_d      = 1'b0;
            carry_d     = CarryBits'(carry_w >> WordBits);
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.word_o       = word_q;
  assign bus.word_valid_o = vld_q;
  assign bus.word_last_o  = last_q;
  assign bus.busy_o       = (col_cnt_q != '0) || (state_q == FLUSH) || vld_q;
endmodule

// File: tb/tb_sq_carry_split.sv
module tb_sq_carry_split;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sq_carry_split_if #(.SumBits(28), .WordBits(16)) bus ();

  sq_carry_split dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame of NumCols identical columns with word_ready_i high.
  // Expected limbs: e0, e1, then er x6, then flush ef with last.
  // If chain is set, sum_valid_i stays high with nxt during the flush cycle.
  task automatic run_frame(input string tag, input logic [27:0] col,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] er, input logic [15:0] ef,
                           input bit chain, input logic [27:0] nxt);
    logic [15:0] e;
    for (int i = 0; i < 8; i++) begin
      bus.sum_i       = col;
      bus.sum_valid_i = 1'b1;
      bus.word_ready_i = 1'b1;
      chk({tag, "_rdy"}, 32'(bus.sum_ready_o), 32'd1);
      step();
      e = (i == 0) ? e0 : (i == 1) ? e1 : er;
      chk({tag, "_word"}, 32'(bus.word_o), 32'(e));
      chk({tag, "_vld"},  32'(bus.word_valid_o), 32'd1);
      chk({tag, "_last"}, 32'(bus.word_last_o), 32'd0);
    end
    if (chain) bus.sum_i = nxt;
    else       bus.sum_valid_i = 1'b0;
    chk({tag, "_flush_rdy"}, 32'(bus.sum_ready_o), 32'd0);
    step();
    chk({tag, "_flush_word"}, 32'(bus.word_o), 32'(ef));
    chk({tag, "_flush_vld"},  32'(bus.word_valid_o), 32'd1);
    chk({tag, "_flush_last"}, 32'(bus.word_last_o), 32'd1);
  endtask

  initial begin
    bus.sum_i        = '0;
    bus.sum_valid_i  = 1'b0;
    bus.word_ready_i = 1'b1;
    #2;
    chk("rst_word", 32'(bus.word_o), 32'd0);
    chk("rst_vld",  32'(bus.word_valid_o), 32'd0);
    chk("rst_last", 32'(bus.word_last_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_rdy", 32'(bus.sum_ready_o), 32'd1);

    // All-ones columns: 9 limbs, 9 cycles.
    run_frame("ones", 28'hFFFFFFF, 16'hFFFF, 16'h0FFE, 16'h0FFF, 16'h1000, 1'b0, '0);
    step();
    chk("ones_idle_vld",  32'(bus.word_valid_o), 32'd0);
    chk("ones_idle_busy", 32'(bus.busy_o), 32'd0);

    // 0x0010000 columns.
    run_frame("p16", 28'h0010000, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 1'b0, '0);
    step();

    // Backpressure after the first limb.
    bus.sum_i = 28'hFFFFFFF;
    bus.sum_valid_i = 1'b1;
    step();
    chk("bp_first", 32'(bus.word_o), 32'hFFFF);
    bus.word_ready_i = 1'b0;
    #1;
    chk("bp_rdy0", 32'(bus.sum_ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_word", 32'(bus.word_o), 32'hFFFF);
      chk("bp_hold_vld",  32'(bus.word_valid_o), 32'd1);
      chk("bp_hold_rdy",  32'(bus.sum_ready_o), 32'd0);
    end
    bus.word_ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      #1;
      chk("bp_rdy", 32'(bus.sum_ready_o), 32'd1);
      step();
      chk("bp_word", 32'(bus.word_o), (i == 1) ? 32'h0FFE : 32'h0FFF);
    end
    bus.sum_valid_i = 1'b0;
    step();
    chk("bp_flush_word", 32'(bus.word_o), 32'h1000);
    chk("bp_flush_last", 32'(bus.word_last_o), 32'd1);
    step();

    // Reset after 3 columns, then an all-zero frame.
    for (int i = 0; i < 3; i++) begin
      bus.sum_i = 28'hFFFFFFF;
      bus.sum_valid_i = 1'b1;
      step();
    end
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    bus.sum_valid_i = 1'b0;
    #1;
    chk("mid_rst_word", 32'(bus.word_o), 32'd0);
    chk("mid_rst_vld",  32'(bus.word_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    step();
    rst = 1'b0;
    step();
    run_frame("zero", 28'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, '0);
    step();

    // Back-to-back frames; flush-cycle sum_valid_i must not be consumed.
    run_frame("b2b_a", 28'hFFFFFFF, 16'hFFFF, 16'h0FFE, 16'h0FFF, 16'h1000, 1'b1, 28'h0010000);
    run_frame("b2b_b", 28'h0010000, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 1'b0, '0);
    step();
    chk("b2b_idle_vld", 32'(bus.word_valid_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
